// File: rtl/id_pkg.sv
// Shared types and helpers for the identifier-scan arbiter: character classes,
// recognizer states, controller states and an ASCII classifier.
package id_pkg;

  typedef enum logic [1:0] {
    ClsOther  = 2'b01,
    ClsNum    = 2'b10,
    ClsLetter = 2'b11
  } char_cls_e;

  typedef enum logic [1:0] {
    CoreS0 = 2'b00,
    CoreS1 = 2'b01,
    CoreS2 = 2'b10
  } core_state_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StFeed   = 2'b01,
    StReport = 2'b10
  } ctrl_state_e;

  // Letters are 'A'..'Z' and 'a'..'z'; digits are '0'..'9'; everything else is other.
  function automatic char_cls_e classify(input logic [7:0] c);
    if ((c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a)) begin
      return ClsLetter;
    end else if (c >= 8'h30 && c <= 8'h39) begin
      return ClsNum;
    end else begin
      return ClsOther;
    end
  endfunction

endpackage

// File: rtl/id_match_core.sv
// Three-state letter-then-digits recognizer. S2 means the characters seen since
// the last clear end in a letter followed by one or more digits.
module id_match_core
  import id_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] char,
  output logic [1:0] state
);

  core_state_e state_q, state_d;

  // Next-state: clear wins over enable; hold when not enabled.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = CoreS0;
    end else if (en) begin
      case (classify(char))
        ClsLetter: state_d = CoreS1;
        ClsNum:    state_d = (state_q == CoreS0) ? CoreS0 : CoreS2;
        default:   state_d = CoreS0;
      endcase
    end
  end

  // Recognizer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CoreS0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/id_scan_arb.sv
// Round-robin arbiter sharing one identifier recognizer between two character
// streams. Grants a requester in IDLE, feeds its token in FEED, and emits a
// one-cycle result in REPORT.
module id_scan_arb
  import id_pkg::*;
#(
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_match,
  output logic [LEN_W-1:0] res_len,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LenMax = '1;

  ctrl_state_e      state_q, state_d;
  logic             gid_q, gid_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             res_id_q;
  logic             res_match_q;
  logic [LEN_W-1:0] res_len_q;

  logic             core_clr;
  logic             core_en;
  logic [7:0]       core_char;
  logic [1:0]       core_state;

  logic             sel_valid;
  logic             sel_last;
  logic             in_report;
  logic             cur_match;

  // Route the granted requester's stream to the recognizer.
  always_comb begin
    sel_valid = gid_q ? req1_valid : req0_valid;
    sel_last  = gid_q ? req1_last  : req0_last;
    core_char = gid_q ? req1_char  : req0_char;
  end

  // Controller next-state, grant selection and length counting.
  always_comb begin
    state_d      = state_q;
    gid_d        = gid_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    core_clr     = 1'b0;
    core_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          // On a tie, favour whoever was not served last.
          gid_d    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          core_clr = 1'b1;
          len_d    = '0;
          state_d  = StFeed;
        end
      end
      StFeed: begin
        // A low valid is a bubble: nothing advances and the grant is kept.
        if (sel_valid) begin
          core_en = 1'b1;
          if (len_q != LenMax) begin
            len_d = len_q + LEN_W'(1);
          end
          if (sel_last) begin
            state_d = StReport;
          end
        end
      end
      StReport: begin
        last_grant_d = gid_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller, grant and length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      gid_q        <= gid_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
    end
  end

  // Capture the reported result so res_* hold their values after REPORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_id_q    <= 1'b0;
      res_match_q <= 1'b0;
      res_len_q   <= '0;
    end else if (in_report) begin
      res_id_q    <= gid_q;
      res_match_q <= cur_match;
      res_len_q   <= len_q;
    end
  end

  id_match_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (core_clr),
    .en    (core_en),
    .char  (core_char),
    .state (core_state)
  );

  // Outputs decode registered state only; ready never depends on valid.
  always_comb begin
    in_report  = (state_q == StReport);
    cur_match  = (core_state == CoreS2);
    req0_ready = (state_q == StFeed) && !gid_q;
    req1_ready = (state_q == StFeed) && gid_q;
    busy       = (state_q != StIdle);
    res_valid  = in_report;
    res_id     = in_report ? gid_q     : res_id_q;
    res_match  = in_report ? cur_match : res_match_q;
    res_len    = in_report ? len_q     : res_len_q;
  end

endmodule

// File: tb/tb_id_scan_arb.sv
// Directed bench for id_scan_arb: single-requester tokens, round-robin ties,
// bubbles, length saturation and mid-token reset.
module tb_id_scan_arb;

  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic [7:0]       req0_char = 8'h00;
  logic             req0_last = 1'b0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [7:0]       req1_char = 8'h00;
  logic             req1_last = 1'b0;
  logic             req1_ready;
  logic             res_valid;
  logic             res_id;
  logic             res_match;
  logic [LEN_W-1:0] res_len;
  logic             busy;

  id_scan_arb #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_char  (req0_char),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_char  (req1_char),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_match  (res_match),
    .res_len    (res_len),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             id;
    logic             match;
    logic [LEN_W-1:0] len;
    int unsigned      cyc;
  } res_t;

  res_t        resq[$];
  int unsigned cyc = 0;
  int unsigned rdy0_cnt = 0;
  int unsigned proto_err = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result capture and handshake invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (res_valid) resq.push_back('{res_id, res_match, res_len, cyc});
    if (req0_ready) rdy0_cnt <= rdy0_cnt + 1;
    if ((req0_ready && req1_ready) || (!busy && (req0_ready || req1_ready)))
      proto_err <= proto_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit who, input bit v, input logic [7:0] c, input bit l);
    if (who) begin
      req1_valid = v; req1_char = c; req1_last = l;
    end else begin
      req0_valid = v; req0_char = c; req0_last = l;
    end
  endtask

  // Hold the current character until a transfer happens at a rising edge.
  task automatic wait_ready(input bit who);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check(who ? "ready1_timeout" : "ready0_timeout", 0, 1);
  endtask

  task automatic send(input bit who, input string s, input int bub_pos, input int bub_len);
    for (int i = 0; i < s.len(); i++) begin
      if (i == bub_pos) begin
        drive(who, 1'b0, 8'h00, 1'b0);
        repeat (bub_len) @(posedge clk);
        #1;
      end
      drive(who, 1'b1, s[i], i == s.len() - 1);
      wait_ready(who);
    end
    drive(who, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_res(input string tag, input bit id, input bit m, input int len,
                            output int unsigned rc);
    res_t r;
    int   n;
    n  = 0;
    rc = 0;
    while (resq.size() == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, resq.size() != 0, 1);
    if (resq.size() != 0) begin
      r  = resq.pop_front();
      rc = r.cyc;
      check({tag, "_id"}, r.id, id);
      check({tag, "_match"}, r.match, m);
      check({tag, "_len"}, r.len, len);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
    check({tag, "_rv"}, res_valid, 0);
    check({tag, "_rid"}, res_id, 0);
    check({tag, "_rmatch"}, res_match, 0);
    check({tag, "_rlen"}, res_len, 0);
  endtask

  initial begin
    int unsigned rc;
    int unsigned start;
    int unsigned snap;
    string       long_s;

    // Reset state
    #12;
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rel_busy", busy, 0);

    // "a12" from requester 0: 3 FEED cycles, result in cycle N+2
    start = cyc;
    snap  = rdy0_cnt;
    send(1'b0, "a12", -1, 0);
    expect_res("a12", 1'b0, 1'b1, 3, rc);
    check("a12_latency", rc - start, 4);
    check("a12_rdy0_cycles", rdy0_cnt - snap, 3);

    // "ab1x" then "9" from requester 1; core is cleared between tokens
    send(1'b1, "ab1x", -1, 0);
    expect_res("ab1x", 1'b1, 1'b0, 4, rc);
    send(1'b1, "9", -1, 0);
    expect_res("nine", 1'b1, 1'b0, 1, rc);
    repeat (3) @(negedge clk);
    check("hold_rv", res_valid, 0);
    check("hold_len", res_len, 1);
    check("hold_id", res_id, 1);

    // Both requesters continuously valid after reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fork
      begin send(1'b0, "z9", -1, 0); send(1'b0, "z9", -1, 0); end
      begin send(1'b1, "z9", -1, 0); send(1'b1, "z9", -1, 0); end
    join
    expect_res("rr0", 1'b0, 1'b1, 2, rc);
    expect_res("rr1", 1'b1, 1'b1, 2, rc);
    expect_res("rr2", 1'b0, 1'b1, 2, rc);
    expect_res("rr3", 1'b1, 1'b1, 2, rc);

    // "q", 3-cycle bubble, "7": grant held while requester 1 waits
    fork
      send(1'b0, "q7", 1, 3);
      begin
        repeat (3) @(posedge clk);
        #1;
        send(1'b1, "x", -1, 0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bubble_busy", busy, 1);
        check("bubble_rdy1", req1_ready, 0);
        check("bubble_rdy0", req0_ready, 1);
      end
    join
    expect_res("q7", 1'b0, 1'b1, 2, rc);
    expect_res("x_after", 1'b1, 1'b0, 1, rc);

    // 39 letters then '5': length saturates at 31
    long_s = "";
    for (int i = 0; i < 39; i++) long_s = {long_s, "b"};
    long_s = {long_s, "5"};
    send(1'b0, long_s, -1, 0);
    expect_res("sat", 1'b0, 1'b1, 31, rc);

    // Reset during "ab3" after 'b': token aborted, no result
    drive(1'b0, 1'b1, "a", 1'b0);
    wait_ready(1'b0);
    drive(1'b0, 1'b1, "b", 1'b0);
    wait_ready(1'b0);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    check_idle_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_res", resq.size(), 0);
    send(1'b0, "c4", -1, 0);
    expect_res("c4", 1'b0, 1'b1, 2, rc);

    repeat (3) @(negedge clk);
    check("extra_results", resq.size(), 0);
    check("protocol", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_scan_arb.md
# id_scan_arb

Round-robin scheduler that shares one identifier-recognition core between two character-stream requesters. Each requester submits a token as a sequence of 8-bit characters with a last flag. The block grants the core to one requester at a time, clears the core before each token and feeds it one character per accepted transfer. When the token ends it emits a one-cycle result: whether the token ends in the letter-then-digits pattern, plus the token length.

## Interface
- LEN_W, 5: width of token-length counter; length saturates at 2^LEN_W-1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 presents a character
- req0_char  in  8  requester 0 character (ASCII)
- req0_last  in  1  requester 0 character is final in token
- req0_ready  out  1  requester 0 character accepted this cycle when valid&ready
- req1_valid, req1_char, req1_last, req1_ready: same as requester 0, for requester 1
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  requester that owned the reported token
- res_match  out  1  token classified as match (core in S2 after last char)
- res_len  out  LEN_W  accepted characters in token, saturating
- busy  out  1  a token is in progress (state != IDLE)

## Operation
- Character class:
  - letter = 'a'..'z' or 'A'..'Z'
  - digit = '0'..'9'
  - other = everything else
- Core states and transitions:
  - letter: from any state -> S1
  - digit: S1->S2, S2->S2, S0->S0
  - other: any state -> S0
  - Core advances only on enable; sync clear forces S0.
- Controller FSM: IDLE, FEED, REPORT.
- IDLE:
  - If neither requester is valid, stay in IDLE.
  - If one is valid, grant it.
  - If both are valid, grant the requester that was not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - On grant: latch gid, clear core, clear len, go to FEED.
  - Both ready outputs are 0 in IDLE.
- FEED:
  - reqN_ready = 1 only for the granted requester; the other stays 0.
  - On valid&ready: core consumes the char and len increments, saturating at 2^LEN_W-1.
  - If last is set on that transfer, go to REPORT.
  - valid low mid-token is a bubble: core and len hold, and the grant is kept indefinitely.
- REPORT:
  - res_valid = 1.
  - res_id = gid.
  - res_match = (core state == S2).
  - res_len = len.
  - last_grant <= gid, then go to IDLE.
  - There is no result backpressure.
- A requester's valid in IDLE does not transfer data; the char is first accepted in FEED.
- A token is at least one character, since last always rides with a char.

## Timing
- Reset values:
  - State = IDLE, core = S0, len = 0, last_grant = 1.
  - req0_ready = req1_ready = 0.
  - res_valid = res_id = res_match = 0, res_len = 0, busy = 0.
- Reset asserted mid-token aborts the token:
  - No result is emitted.
  - The requester must resubmit from the first char.
- Latency for an N-char token with no bubbles:
  - 1 grant cycle (IDLE), then N FEED cycles.
  - res_valid is asserted in cycle N+2, counted from the first IDLE cycle with valid.
- REPORT -> IDLE -> next FEED: a minimum of 2 dead cycles between tokens.
- res_* are held at their last values outside REPORT; only res_valid qualifies them.
- Simultaneous valid on both requesters in the same IDLE cycle is resolved by last_grant, never by fixed priority.
- Ready is a registered function of state/gid, never combinationally dependent on valid.

## Structure
- Shared package id_pkg holds:
  - character-class encoding: OTHER=2'b01, NUM=2'b10, LETTER=2'b11
  - core state encoding: S0=2'b00, S1=2'b01, S2=2'b10
  - controller state encoding: IDLE, FEED, REPORT
  - an ASCII classification function
- Sub-module id_match_core:
  - Ports: clk, rst_n, clr, en, char[7:0], state[1:0].
  - Contains the 3-state recognizer with synchronous clear and enable.
- Top id_scan_arb contains the controller FSM, round-robin pointer, length counter and result registers.

## Test plan
- Req0 alone sends "a12" (last on '2') -> req0_ready high for 3 FEED cycles; res_valid once with id=0, match=1, len=3.
- Req1 alone sends "ab1x" -> res_valid with id=1, match=0, len=4; core cleared, so a following token "9" gives match=0, len=1.
- Both valid continuously after reset, each sending "z9" repeatedly -> grants alternate 0,1,0,1; req1_ready is never high while gid=0.
- Req0 sends "q", bubble of 3 cycles with valid low, then "7" last -> grant held through bubble; match=1, len=2; req1 valid during bubble is not granted.
- Req0 sends 40 letters ending in "5" with LEN_W=5 -> len saturates at 31; match=1.
- rst_n pulsed low while req0 is mid-token "ab3" after 'b' -> all outputs 0 immediately; no res_valid for that token; next token "c4" -> match=1, len=2.
